// File: rtl/divider_controller.sv
// rtl/divider_controller.sv - sequencing FSM for the restoring shift-subtract divider.
// Optional divide-by-zero early exit is enabled by defining DIV_ZERO_TRAP_EN.
module divider_controller #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Divisor_zero,
    input  logic             ALU_ge,
    output logic             W_ctrl,
    output logic             Rem_load,
    output logic             Rem_write,
    output logic             Rem_shift,
    output logic             Rem_lsb,
    output logic             Rem_fix,
    output logic [CNT_W-1:0] Iter_cnt,
    output logic             Busy,
    output logic             Done,
    output logic             Div_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_err_q, div_err_d;
    logic             zero_trap;

`ifdef DIV_ZERO_TRAP_EN
    assign zero_trap = Divisor_zero;
`else
    logic unused_divisor_zero;
    assign unused_divisor_zero = Divisor_zero;
    assign zero_trap = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_err_d = div_err_q;
        W_ctrl    = 1'b0;
        Rem_load  = 1'b0;
        Rem_write = 1'b0;
        Rem_shift = 1'b0;
        Rem_lsb   = 1'b0;
        Rem_fix   = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        Div_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                W_ctrl    = 1'b1;
                Rem_load  = 1'b1;
                Busy      = 1'b1;
                cnt_d     = '0;
                div_err_d = zero_trap;
                state_d   = zero_trap ? S_DONE : S_ITER;
            end
            S_ITER: begin
                Busy      = 1'b1;
                Rem_shift = 1'b1;
                Rem_write = ALU_ge;
                Rem_lsb   = ALU_ge;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                Rem_fix = 1'b1;
                Busy    = 1'b1;
                cnt_d   = CNT_FULL;
                state_d = S_DONE;
            end
            S_DONE: begin
                Done    = 1'b1;
                Div_err = div_err_q;
                // Counter returns to 0 so IDLE presents all-zero outputs.
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_err_q <= div_err_d;
        end
    end

    assign Iter_cnt = cnt_q;

endmodule

// File: tb/tb_divider_controller.sv
// tb/tb_divider_controller.sv - directed bench with a behavioural datapath and sequence model.
module tb_divider_controller;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int K_DONE = WIDTH + 3;
`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic             CLK;
    logic             Reset;
    logic             Start;
    logic             Divisor_zero;
    logic             ALU_ge;
    logic             W_ctrl, Rem_load, Rem_write, Rem_shift, Rem_lsb, Rem_fix;
    logic [CNT_W-1:0] Iter_cnt;
    logic             Busy, Done, Div_err;

    logic [31:0] dividend_in, divisor_in, div_reg;
    logic [63:0] rem;
    int          checks = 0;
    int          errors = 0;
    int          run_cyc = 0;
    bit          model_ok = 1'b0;
    bit          err_exp = 1'b0;

    divider_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Divisor_zero(Divisor_zero),
        .ALU_ge(ALU_ge), .W_ctrl(W_ctrl), .Rem_load(Rem_load), .Rem_write(Rem_write),
        .Rem_shift(Rem_shift), .Rem_lsb(Rem_lsb), .Rem_fix(Rem_fix), .Iter_cnt(Iter_cnt),
        .Busy(Busy), .Done(Done), .Div_err(Div_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign Divisor_zero = (divisor_in == 32'd0);
    assign ALU_ge       = (rem[63:32] >= div_reg);

    // Datapath: divisor register, 2*WIDTH remainder register, subtract/compare ALU.
    always @(posedge CLK) begin
        logic [63:0] tmp;
        tmp = {(Rem_write ? rem[63:32] - div_reg : rem[63:32]), rem[31:0]};
        if (W_ctrl) div_reg <= divisor_in;
        if (Rem_load) rem <= {32'd0, dividend_in} << 1;
        else if (Rem_shift) rem <= {tmp[62:0], Rem_lsb};
        else if (Rem_fix) rem <= {1'b0, rem[63:33], rem[31:0]};
    end

    // Cycle position within a run: 1 = LOAD, 2..WIDTH+1 = ITER, WIDTH+2 = FIX, WIDTH+3 = DONE.
    always @(posedge CLK) begin
        if (Reset) begin
            run_cyc  <= 0;
            model_ok <= 1'b1;
        end else if (run_cyc == 0) begin
            if (Start) run_cyc <= 1;
        end else if (run_cyc == 1) begin
            err_exp <= TRAP && Divisor_zero;
            run_cyc <= (TRAP && Divisor_zero) ? K_DONE : 2;
        end else if (run_cyc == K_DONE) begin
            run_cyc <= 0;
        end else begin
            run_cyc <= run_cyc + 1;
        end
    end

    always @(negedge CLK) begin
        logic [14:0] act, expv, mask;
        if (model_ok) begin
            act  = {W_ctrl, Rem_load, Rem_write, Rem_shift, Rem_lsb, Rem_fix, Busy, Done, Div_err, Iter_cnt};
            expv = '0;
            mask = '1;
            if (run_cyc == 1) begin
                expv[14] = 1'b1; expv[13] = 1'b1; expv[8] = 1'b1;
                mask[6:0] = '0;
            end else if (run_cyc >= 2 && run_cyc <= WIDTH + 1) begin
                expv[12] = ALU_ge; expv[11] = 1'b1; expv[10] = ALU_ge; expv[8] = 1'b1;
                expv[5:0] = 6'(run_cyc - 2);
                mask[6] = 1'b0;
            end else if (run_cyc == WIDTH + 2) begin
                expv[9] = 1'b1; expv[8] = 1'b1; expv[5:0] = 6'(WIDTH);
                mask[6] = 1'b0;
            end else if (run_cyc == K_DONE) begin
                expv[7] = 1'b1; expv[6] = err_exp; expv[5:0] = 6'(WIDTH);
                if (err_exp) mask[5:0] = '0;
            end
            checks++;
            if (((act ^ expv) & mask) != 0) begin
                errors++;
                $display("FAIL outputs k=%0d got=%b want=%b mask=%b", run_cyc, act, expv, mask);
            end
            checks++;
            if ($countones({Rem_load, Rem_shift, Rem_fix}) > 1) begin
                errors++;
                $display("FAIL rem_strobes got=%b want at most one", {Rem_load, Rem_shift, Rem_fix});
            end
            if (Done) begin
                checks++;
                if (Busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_with_done got=%b want=0", Busy);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, expv);
        end
    endtask

    // Called at a negedge with the DUT idle; Start is seen at the next edge (edge 0).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                           input logic [31:0] r, input bit e, input int done_cyc,
                           input int iters_exp, input bit check_res);
        int cyc = 0;
        int iters = 0;
        bit got = 1'b0;
        dividend_in = a;
        divisor_in  = b;
        Start       = 1'b1;
        while (cyc < 100 && !got) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) Start = 1'b0;
            if (Rem_shift) iters++;
            if (Done) got = 1'b1;
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("done_cycle", 64'(cyc), 64'(done_cyc));
        chk("div_err", 64'(Div_err), 64'(e));
        chk("iter_cycles", 64'(iters), 64'(iters_exp));
        if (check_res) begin
            chk("quotient", 64'(rem[31:0]), 64'(q));
            chk("remainder", 64'(rem[63:32]), 64'(r));
        end
        @(negedge CLK);
    endtask

    initial begin
        int cyc;
        int dones;
        int done1, load2, done2;
        bit done_seen;
        logic [31:0] q1, r1;
        Reset = 1'b1;
        Start = 1'b0;
        dividend_in = '0;
        divisor_in  = 32'd1;
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("reset_outputs", 64'({W_ctrl, Rem_load, Rem_write, Rem_shift, Rem_lsb, Rem_fix,
                                  Busy, Done, Div_err, Iter_cnt}), 64'd0);

        run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35, 32, 1'b1);

        // Start held across a whole run: second run starts in the IDLE after DONE.
        dividend_in = 32'hFFFF_FFFF;
        divisor_in  = 32'd1;
        Start = 1'b1;
        cyc = 0; dones = 0; done1 = 0; load2 = 0; done2 = 0; q1 = '0; r1 = '1;
        while (cyc < 90) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 40) Start = 1'b0;
            if (Done) begin
                dones++;
                if (dones == 1) begin
                    done1 = cyc; q1 = rem[31:0]; r1 = rem[63:32];
                end else begin
                    done2 = cyc;
                end
            end
            if (W_ctrl && cyc > 1 && load2 == 0) load2 = cyc;
        end
        chk("held_done_count", 64'(dones), 64'd2);
        chk("held_done1_cycle", 64'(done1), 64'd35);
        chk("held_quotient", 64'(q1), 64'hFFFF_FFFF);
        chk("held_remainder", 64'(r1), 64'd0);
        chk("held_load2_cycle", 64'(load2), 64'd37);
        chk("held_done2_cycle", 64'(done2), 64'd71);
        chk("held_quotient2", 64'(rem[31:0]), 64'hFFFF_FFFF);

        // Reset in the ITER cycle where Iter_cnt is 10.
        dividend_in = 32'd100;
        divisor_in  = 32'd7;
        Start = 1'b1;
        cyc = 0;
        while (cyc < 12) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) Start = 1'b0;
        end
        chk("iter_cnt_before_reset", 64'(Iter_cnt), 64'd10);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        chk("after_reset_busy", 64'(Busy), 64'd0);
        chk("after_reset_cnt", 64'(Iter_cnt), 64'd0);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (Done) done_seen = 1'b1;
        end
        chk("no_done_after_reset", 64'(done_seen), 64'd0);
        run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 35, 32, 1'b1);

`ifdef DIV_ZERO_TRAP_EN
        run_div(32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 2, 0, 1'b0);
`else
        run_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 35, 32, 1'b1);
`endif
        run_div(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 35, 32, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
